// File: rtl/elbeth_dmem_interface.sv
// Data-memory port adapter: byte/half/word core accesses to a word-wide bus with byte enables.
// Latency: core_ready 2 cycles after core_en with a zero-wait memory (+1 per wait cycle), 1 cycle on misalignment.
// Backpressure: holds mem_en until mem_ready/mem_error or timeout; stalls the core while an access is in flight.
module elbeth_dmem_interface #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_en,
   input  logic        core_wr,
   input  logic [1:0]  core_size,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_w_data,
   output logic [31:0] core_r_data,
   output logic        core_ready,
   output logic        core_error,
   output logic [1:0]  core_err_code,
   output logic        core_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_byte_en,
   output logic [31:0] mem_w_data,
   input  logic [31:0] mem_r_data,
   input  logic        mem_ready,
   input  logic        mem_error
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_BUS     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE, ST_ERR} state_t;

   state_t        state, state_nxt;
   logic          hold_wr;
   logic [1:0]    hold_size;
   logic [31:0]   hold_addr;
   logic [31:0]   hold_w_data;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    err_code_q;
   logic [31:0]   r_data_q;

   logic          req_bad;
   logic          in_bus;
   logic          timed_out;
   logic [4:0]    lane_shift;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wd;
   logic [31:0]   rd_shifted;
   logic [31:0]   rd_masked;

   assign in_bus     = (state == ST_BUS);
   assign timed_out  = (wait_cnt == CNT_LAST);
   assign lane_shift = {hold_addr[1:0], 3'b000};

   // Alignment check on the live request, evaluated when it is sampled in IDLE.
   always_comb begin
      req_bad = 1'b0;
      case (core_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = core_addr[0];
         2'b10:   req_bad = |core_addr[1:0];
         default: req_bad = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; a bus error takes priority over a simultaneous ready.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (core_en) state_nxt = req_bad ? ST_ERR : ST_BUS;
         ST_BUS: begin
            if (mem_error)      state_nxt = ST_ERR;
            else if (mem_ready) state_nxt = ST_DONE;
            else if (timed_out) state_nxt = ST_ERR;
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Capture the request once in IDLE so the core inputs are free afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_wr     <= 1'b0;
         hold_size   <= 2'b00;
         hold_addr   <= '0;
         hold_w_data <= '0;
      end else if (state == ST_IDLE && core_en) begin
         hold_wr     <= core_wr;
         hold_size   <= core_size;
         hold_addr   <= core_addr;
         hold_w_data <= core_w_data;
      end
   end

   // Wait counter: zero on BUS entry, counts BUS cycles that got no response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    wait_cnt <= '0;
      else if (state == ST_IDLE)                   wait_cnt <= '0;
      else if (in_bus && !mem_ready && !mem_error) wait_cnt <= wait_cnt + 1'b1;
   end

   // Error cause, latched for presentation during the ERR cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_code_q <= 2'b00;
      end else if (state == ST_IDLE && core_en && req_bad) begin
         err_code_q <= ERR_ALIGN;
      end else if (in_bus) begin
         if (mem_error)                    err_code_q <= ERR_BUS;
         else if (!mem_ready && timed_out) err_code_q <= ERR_TIMEOUT;
      end
   end

   // Store lane steering and byte enables from the captured request.
   always_comb begin
      lane_be = 4'b1111;
      lane_wd = hold_w_data;
      case (hold_size)
         2'b00: begin
            lane_be = 4'b0001 << hold_addr[1:0];
            lane_wd = {24'h0, hold_w_data[7:0]} << lane_shift;
         end
         2'b01: begin
            lane_be = hold_addr[1] ? 4'b1100 : 4'b0011;
            lane_wd = hold_addr[1] ? {hold_w_data[15:0], 16'h0} : {16'h0, hold_w_data[15:0]};
         end
         default: begin
            lane_be = 4'b1111;
            lane_wd = hold_w_data;
         end
      endcase
   end

   // Load alignment: shift the addressed lane down and zero-fill above the size.
   always_comb begin
      rd_shifted = mem_r_data >> lane_shift;
      case (hold_size)
         2'b00:   rd_masked = {24'h0, rd_shifted[7:0]};
         2'b01:   rd_masked = {16'h0, rd_shifted[15:0]};
         default: rd_masked = rd_shifted;
      endcase
   end

   // Load data register; only a successful load updates it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                         r_data_q <= '0;
      else if (in_bus && mem_ready && !mem_error && !hold_wr) r_data_q <= rd_masked;
   end

   assign core_r_data   = r_data_q;
   assign core_ready    = (state == ST_DONE) || (state == ST_ERR);
   assign core_error    = (state == ST_ERR);
   assign core_err_code = (state == ST_ERR) ? err_code_q : 2'b00;
   // Gated by reset so the pipeline is released as soon as reset asserts.
   assign core_stall    = rst & core_en & ~core_ready;

   assign mem_en      = in_bus;
   assign mem_we      = in_bus & hold_wr;
   assign mem_addr    = in_bus ? {hold_addr[31:2], 2'b00} : 32'h0;
   assign mem_byte_en = in_bus ? lane_be : 4'h0;
   assign mem_w_data  = in_bus ? lane_wd : 32'h0;

endmodule
